twiddle_gen: RTL and testbench
==============================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 Parameter WIDTH, default 8: signed twiddle component width; full scale S = 2^(WIDTH-1)-1.
REQ-002 Parameter N, default 64: FFT size; power of two, 4..1024.
REQ-003 Parameter STAGE, default 0: radix-2^2 stage index; subframe length L = N/4^STAGE; elaboration error unless L >= 4.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  one twiddle request per cycle when high.
REQ-007 in_sync  input  1  frame start; honoured only when in_valid=1.
REQ-008 inverse  input  1  1 = IFFT (conjugate twiddle); sampled with in_valid.
REQ-009 tw_valid  output  1  tw_re/tw_im/tw_last valid.
REQ-010 tw_re  output  WIDTH  signed real part, registered.
REQ-011 tw_im  output  WIDTH  signed imaginary part, registered.
REQ-012 tw_last  output  1  marks the twiddle for k = L-1.

Function
REQ-013 Sample counter k, log2(L) bits, SHALL advance by 1 only on cycles with in_valid=1 and wrap L-1 -> 0.
REQ-014 in_valid=1 with in_sync=1 SHALL force this sample to k=0; next accepted sample is k=1; in_sync overrides any counter value (mid-frame resync).
REQ-015 in_valid=0 SHALL hold k; no skipped or repeated indices.
REQ-016 Exponent: r = k / (L/4), m = k mod (L/4); e = 0, 2m, m, 3m for r = 0,1,2,3 (bit-reversed order); e < 3L/4 always.
REQ-017 Twiddle SHALL equal W_L^e = cos(2*pi*e/L) - j*sin(2*pi*e/L), scaled by S.
REQ-018 Quarter-wave table C[i] = round(S*cos(2*pi*i/L)), i = 0..L/4, fixed at elaboration; no other storage of sine/cosine.
REQ-019 Folding, d = offset within region: e in [0,L/4): re=C[e], im=-C[L/4-e]; e in [L/4,L/2), d=e-L/4: re=-C[L/4-d], im=-C[d]; e in [L/2,3L/4), d=e-L/2: re=-C[d], im=+C[L/4-d].
REQ-020 inverse=1 SHALL negate im (conjugate); inverse travels in the pipeline with its sample, so changes take effect per sample.
REQ-021 Negation of S never overflows (result -S); no saturation logic needed.
REQ-022 Latency: fixed 2 cycles; request accepted at cycle t yields tw_valid=1 at t+2; pipeline stage 1 registers e, region, inverse, last; stage 2 registers table read, sign folding.
REQ-023 tw_valid SHALL be in_valid delayed by exactly 2 cycles; gaps in input appear identically at output.
REQ-024 tw_re/tw_im/tw_last SHALL hold their last value while tw_valid=0.
REQ-025 tw_last=1 exactly when the emitted sample had k=L-1, else 0.

Reset
REQ-026 rst=1 at a clock edge SHALL set k=0, all pipeline valids 0, tw_valid=0, tw_last=0, tw_re=0, tw_im=0.
REQ-027 rst SHALL discard in-flight requests; first accepted sample after rst deasserts is k=0 whether or not in_sync is asserted.
REQ-028 rst has priority over in_valid/in_sync in the same cycle.

Verification (WIDTH=8, N=16, STAGE=0: L=16, S=127, C = 127,117,90,49,0)
REQ-029 rst, then in_sync+in_valid, 16 back-to-back valids -> from cycle 2 on, k=0..3 give (127,0); k=5 (90,-90); k=13 (49,-117); k=14 (-90,-90); k=15 (-117,49) with tw_last=1.
REQ-030 Same stream with inverse=1 on k=13 only -> k=13 gives (49,117); k=12 and k=14 unchanged.
REQ-031 in_valid toggled 1,0,0,1 around k=6,7 -> tw_valid pattern 1,0,0,1 delayed 2 cycles; k=6 (0,-127), k=7 (-90,-90); no index skipped.
REQ-032 in_sync+in_valid at k=9 mid-frame -> that sample emits (127,0) as k=0; following sample k=1; tw_last appears 15 samples later.
REQ-033 rst asserted with two requests in flight -> tw_valid=0, outputs 0 on next two cycles; next accepted sample emits k=0.
REQ-034 N=64, STAGE=1 (L=16) -> identical sequence to REQ-029; N=64, STAGE=2 (L=4) -> k=0..3 give (127,0),(127,0),(127,0),(127,0).

Source files
------------

// File: rtl/twiddle_gen_if.sv
// Request/twiddle bus for twiddle_gen: requests flow in, registered twiddles flow out.
interface twiddle_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic                    in_valid;
  logic                    in_sync;
  logic                    inverse;
  logic                    tw_valid;
  logic signed [WIDTH-1:0] tw_re;
  logic signed [WIDTH-1:0] tw_im;
  logic                    tw_last;

  modport master (
    output in_valid, in_sync, inverse,
    input  tw_valid, tw_re, tw_im, tw_last
  );

  modport slave (
    input  in_valid, in_sync, inverse,
    output tw_valid, tw_re, tw_im, tw_last
  );
endinterface

// File: rtl/twiddle_gen.sv
// Radix-2^2 FFT twiddle generator: bit-reversed exponent sequencing, quarter-wave
// cosine table with sign folding, fixed two-cycle latency.
module twiddle_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 64,
  parameter int unsigned STAGE = 0
) (
  input logic        clk,
  input logic        rst,
  twiddle_gen_if.slave bus
);

  localparam int unsigned L  = N >> (2 * STAGE);
  localparam int unsigned KW = $clog2(L);
  localparam int unsigned Q  = L / 4;
  localparam int unsigned AW = $clog2(Q + 1);
  localparam longint      S  = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;

  if (N < 4 || N > 1024 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("twiddle_gen: N must be a power of two in 4..1024");
  end
  if (L < 4) begin : g_bad_l
    $error("twiddle_gen: subframe length N/4^STAGE must be at least 4");
  end

  // round(S*cos(2*pi*i/L)) via Q30 fixed-point Taylor series, evaluated at elaboration
  function automatic longint cos_q(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (64'sd6746518852 * longint'(i)) / longint'(L);
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return (S * sum + (64'sd1 <<< 29)) >>> 30;
  endfunction

  logic signed [WIDTH-1:0] ctab [Q+1];

  for (genvar g = 0; g <= int'(Q); g++) begin : g_tab
    localparam longint CV = cos_q(g);
    assign ctab[g] = WIDTH'(CV);
  end

  logic [KW-1:0] k_q;
  logic [KW-1:0] k_cur;
  logic [KW-1:0] m_c;
  logic [KW-1:0] e_c;
  logic [KW-1:0] d_c;
  logic [1:0]    reg_c;
  logic          last_c;

  // Sample index and bit-reversed exponent for the request in this cycle
  always_comb begin : idx_comb
    e_c   = '0;
    k_cur = bus.in_sync ? '0 : k_q;
    m_c   = k_cur & KW'(Q - 1);
    unique case (k_cur[KW-1 -: 2])
      2'd0:    e_c = '0;
      2'd1:    e_c = m_c << 1;
      2'd2:    e_c = m_c;
      default: e_c = m_c + (m_c << 1);
    endcase
  end

  assign reg_c  = e_c[KW-1 -: 2];
  assign d_c    = e_c & KW'(Q - 1);
  assign last_c = (k_cur == KW'(L - 1));

  logic          s1_valid;
  logic          s1_inv;
  logic          s1_last;
  logic [1:0]    s1_reg;
  logic [KW-1:0] s1_d;

  // Counter and stage 1
  always_ff @(posedge clk) begin : stage1
    if (rst) begin
      k_q      <= '0;
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_last  <= 1'b0;
      s1_reg   <= '0;
      s1_d     <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        k_q     <= k_cur + KW'(1);
        s1_inv  <= bus.inverse;
        s1_last <= last_c;
        s1_reg  <= reg_c;
        s1_d    <= d_c;
      end
    end
  end

  logic [AW-1:0]           idx_a;
  logic [AW-1:0]           idx_b;
  logic signed [WIDTH-1:0] ca;
  logic signed [WIDTH-1:0] cb;
  logic signed [WIDTH-1:0] re_c;
  logic signed [WIDTH-1:0] im_c;

  assign idx_a = AW'(s1_d);
  assign idx_b = AW'(KW'(Q) - s1_d);
  assign ca    = ctab[idx_a];
  assign cb    = ctab[idx_b];

  // Fold the quarter-wave table into the three used octant pairs; conjugate on inverse
  always_comb begin : fold_comb
    re_c = '0;
    im_c = '0;
    unique case (s1_reg)
      2'd0: begin
        re_c = ca;
        im_c = -cb;
      end
      2'd1: begin
        re_c = -cb;
        im_c = -ca;
      end
      default: begin
        re_c = -ca;
        im_c = cb;
      end
    endcase
    if (s1_inv) begin
      im_c = -im_c;
    end
  end

  // Stage 2 output registers hold their value across gaps
  always_ff @(posedge clk) begin : stage2
    if (rst) begin
      bus.tw_valid <= 1'b0;
      bus.tw_re    <= '0;
      bus.tw_im    <= '0;
      bus.tw_last  <= 1'b0;
    end else begin
      bus.tw_valid <= s1_valid;
      if (s1_valid) begin
        bus.tw_re   <= re_c;
        bus.tw_im   <= im_c;
        bus.tw_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: three configurations (L=16, L=16 via STAGE=1, L=4) share one stimulus.
module tb_twiddle_gen;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_sync;
  logic inverse;

  always #5 clk = ~clk;

  twiddle_gen_if #(.WIDTH(8)) i0 ();
  twiddle_gen_if #(.WIDTH(8)) i1 ();
  twiddle_gen_if #(.WIDTH(8)) i2 ();

  assign i0.in_valid = in_valid;
  assign i0.in_sync  = in_sync;
  assign i0.inverse  = inverse;
  assign i1.in_valid = in_valid;
  assign i1.in_sync  = in_sync;
  assign i1.inverse  = inverse;
  assign i2.in_valid = in_valid;
  assign i2.in_sync  = in_sync;
  assign i2.inverse  = inverse;

  twiddle_gen #(.WIDTH(8), .N(16), .STAGE(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  twiddle_gen #(.WIDTH(8), .N(64), .STAGE(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  twiddle_gen #(.WIDTH(8), .N(64), .STAGE(2)) u2 (.clk(clk), .rst(rst), .bus(i2));

  logic              o_v    [3];
  logic signed [7:0] o_re   [3];
  logic signed [7:0] o_im   [3];
  logic              o_last [3];

  assign o_v[0] = i0.tw_valid;  assign o_re[0] = i0.tw_re;  assign o_im[0] = i0.tw_im;  assign o_last[0] = i0.tw_last;
  assign o_v[1] = i1.tw_valid;  assign o_re[1] = i1.tw_re;  assign o_im[1] = i1.tw_im;  assign o_last[1] = i1.tw_last;
  assign o_v[2] = i2.tw_valid;  assign o_re[2] = i2.tw_re;  assign o_im[2] = i2.tw_im;  assign o_last[2] = i2.tw_last;

  int checks   = 0;
  int failures = 0;

  // Reference model state: next index, request pending in the pipe, visible outputs
  int lsz   [3] = '{16, 16, 4};
  int mk    [3];
  int pv    [3];
  int pre   [3];
  int pim   [3];
  int plast [3];
  int ov    [3];
  int ore   [3];
  int oim   [3];
  int olast [3];

  bit cap_en = 1'b0;
  int cap_re[$];
  int cap_im[$];
  int cap_last[$];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int exponent(input int k, input int l);
    int q;
    int r;
    int m;
    q = l / 4;
    r = k / q;
    m = k % q;
    case (r)
      0:       return 0;
      1:       return 2 * m;
      2:       return m;
      default: return 3 * m;
    endcase
  endfunction

  task automatic model_update();
    int k;
    real th;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mk[d] = 0; pv[d] = 0; ov[d] = 0; ore[d] = 0; oim[d] = 0; olast[d] = 0;
      end else begin
        ov[d] = pv[d];
        if (pv[d] != 0) begin
          ore[d] = pre[d]; oim[d] = pim[d]; olast[d] = plast[d];
        end
        if (in_valid) begin
          k        = in_sync ? 0 : mk[d];
          th       = 2.0 * 3.14159265358979 * real'(exponent(k, lsz[d])) / real'(lsz[d]);
          pre[d]   = rnd(127.0 * $cos(th));
          pim[d]   = -rnd(127.0 * $sin(th));
          if (inverse) pim[d] = -pim[d];
          plast[d] = (k == lsz[d] - 1) ? 1 : 0;
          mk[d]    = (k + 1) % lsz[d];
          pv[d]    = 1;
        end else begin
          pv[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic inv, input logic r);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    inverse  = inv;
    rst      = r;
    @(posedge clk);
    model_update();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("tw_valid", d, int'(o_v[d]), ov[d]);
      chk("tw_re",    d, int'(o_re[d]), ore[d]);
      chk("tw_im",    d, int'(o_im[d]), oim[d]);
      chk("tw_last",  d, int'(o_last[d]), olast[d]);
    end
    if (cap_en && o_v[0]) begin
      cap_re.push_back(int'(o_re[0]));
      cap_im.push_back(int'(o_im[0]));
      cap_last.push_back(int'(o_last[0]));
    end
  endtask

  // Expected L=16 twiddles for k=0..15 in bit-reversed exponent order
  int tab_re [16] = '{127, 127, 127, 127, 127, 90, 0, -90, 127, 117, 90, 49, 127, 49, -90, -117};
  int tab_im [16] = '{0, 0, 0, 0, 0, -90, -127, -90, 0, -49, -90, -117, 0, -117, -90, 49};

  initial begin
    in_valid = 1'b0;
    in_sync  = 1'b0;
    inverse  = 1'b0;
    rst      = 1'b1;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Full frame from sync, captured on the L=16 instance
    cap_en = 1'b1;
    for (int k = 0; k < 16; k++) step(1, k == 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    chk("frame_len", 0, cap_re.size(), 16);
    for (int k = 0; k < 16 && k < cap_re.size(); k++) begin
      chk($sformatf("frame_re_k%0d", k), 0, cap_re[k], tab_re[k]);
      chk($sformatf("frame_im_k%0d", k), 0, cap_im[k], tab_im[k]);
      chk($sformatf("frame_last_k%0d", k), 0, cap_last[k], (k == 15) ? 1 : 0);
    end

    // Conjugate on k=13 only
    for (int k = 0; k < 16; k++) step(1, k == 0, k == 13, 0);

    // Input gaps around k=6,7
    for (int k = 0; k < 7; k++) step(1, k == 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 7; k < 16; k++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Mid-frame resync at k=9
    for (int k = 0; k < 9; k++) step(1, k == 0, 0, 0);
    step(1, 1, 0, 0);
    for (int k = 1; k < 17; k++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset with requests in flight, then restart without sync
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset with valid and sync asserted: reset wins
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 2) == 1, ($urandom % 100) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
